// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM encoding, access-size
// codes, the latched request record and the alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } lsu_state_e;

    localparam logic [1:0] MASK_B = 2'b01;
    localparam logic [1:0] MASK_H = 2'b10;
    localparam logic [1:0] MASK_W = 2'b11;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mask;
        logic        uns;
        logic        store;
    } lsu_req_t;

    // Encoding 00 falls into the word case, like everywhere else in the unit.
    function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] off);
        case (mask)
            MASK_B:  return 1'b0;
            MASK_H:  return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface lsu_ctrl_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load extraction with sign/zero extension. Low address bits are forced aligned.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  mask,
    input  logic [1:0]  offset,
    input  logic        ld_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_ext
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        lane = 2'b00;
        case (mask)
            MASK_B:  lane = offset;
            MASK_H:  lane = {offset[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        be       = 4'b1111;
        st_lanes = st_data;
        ld_ext   = shifted;
        case (mask)
            MASK_B: begin
                be       = 4'b0001 << lane;
                st_lanes = {4{st_data[7:0]}};
                ld_ext   = ld_unsigned ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            end
            MASK_H: begin
                be       = 4'b0011 << lane;
                st_lanes = {2{st_data[15:0]}};
                ld_ext   = ld_unsigned ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: IDLE/BUSY/DONE/ERR handshake to data memory with timeout.
// Optional misaligned-access trap when LSU_MISALIGN_TRAP_EN is defined.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd_en,
    input  logic        mem_wrt_en,
    input  logic [1:0]  mem_mask,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        bus_err,
    output logic        misalign,
    lsu_ctrl_if.master  dmem
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

    lsu_state_e  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        mis_q, mis_d;

    logic        req_any, mis_req;
    logic [3:0]  be_w;
    logic [31:0] st_lanes, ld_ext;

    assign req_any = mem_rd_en | mem_wrt_en;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_req = is_misaligned(mem_mask, addr[1:0]);
`else
    assign mis_req = 1'b0;
`endif

    lsu_align u_align (
        .mask        (req_q.mask),
        .offset      (req_q.addr[1:0]),
        .ld_unsigned (req_q.uns),
        .st_data     (req_q.wdata),
        .rd_word     (dmem.dmem_rdata),
        .be          (be_w),
        .st_lanes    (st_lanes),
        .ld_ext      (ld_ext)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            ld_data_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            mis_q     <= mis_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;
        mis_d     = mis_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    req_d.addr  = addr;
                    req_d.wdata = wdata;
                    req_d.mask  = mem_mask;
                    req_d.uns   = ld_unsigned;
                    req_d.store = mem_wrt_en;
                    mis_d       = mis_req;
                    cnt_d       = 16'd1;
                    if (mis_req) begin
                        state_d   = ST_ERR;
                        ld_data_d = '0;
                    end else begin
                        state_d   = ST_BUSY;
                    end
                end
            end
            // cnt_q holds the number of the current BUSY cycle; an ack beats the timeout.
            ST_BUSY: begin
                if (dmem.dmem_ack) begin
                    state_d = ST_DONE;
                    if (!req_q.store) ld_data_d = ld_ext;
                end else if (cnt_q == TMO) begin
                    state_d   = ST_ERR;
                    ld_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                mis_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall           = 1'b0;
        ld_valid        = 1'b0;
        bus_err         = 1'b0;
        misalign        = 1'b0;
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_wdata = '0;
        dmem.dmem_be    = '0;
        case (state_q)
            ST_IDLE: stall = req_any;
            ST_BUSY: begin
                stall           = 1'b1;
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = req_q.store;
                dmem.dmem_addr  = {req_q.addr[31:2], 2'b00};
                dmem.dmem_wdata = st_lanes;
                dmem.dmem_be    = be_w;
            end
            ST_DONE: ld_valid = !req_q.store;
            default: begin
                bus_err  = !mis_q;
                misalign = mis_q;
            end
        endcase
    end

    assign ld_data = ld_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl (TIMEOUT_CYC=4); honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd_en, mem_wrt_en, ld_unsigned;
    logic [1:0]  mem_mask;
    logic [31:0] addr, wdata;
    logic        stall, ld_valid, bus_err, misalign;
    logic [31:0] ld_data;
    int          checks = 0;
    int          failures = 0;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_rd_en   (mem_rd_en),
        .mem_wrt_en  (mem_wrt_en),
        .mem_mask    (mem_mask),
        .ld_unsigned (ld_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .ld_data     (ld_data),
        .ld_valid    (ld_valid),
        .bus_err     (bus_err),
        .misalign    (misalign),
        .dmem        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] m, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
        mem_rd_en = rd; mem_wrt_en = wr; mem_mask = m; ld_unsigned = u; addr = a; wdata = d;
        #1;
    endtask

    // Garbage on the request inputs shows the unit works from latched values.
    task automatic idle_in();
        mem_rd_en = 1'b0; mem_wrt_en = 1'b0; mem_mask = 2'b01; ld_unsigned = 1'b1;
        addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
        #1;
    endtask

    task automatic ack(input logic [31:0] d);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = d;
        #1;
    endtask

    task automatic noack();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_rd_en = 1'b0; mem_wrt_en = 1'b0; mem_mask = 2'b00; ld_unsigned = 1'b0;
        addr = '0; wdata = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        step(); step();
        chk("rst_stall", stall, 0);
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_be", bus.dmem_be, 0);
        chk("rst_valid", ld_valid, 0);
        chk("rst_buserr", bus_err, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_ld_data", ld_data, 0);
        rst_n = 1'b1;
        step();

        // lw 0x100, ack in the second BUSY cycle
        req(1, 0, MASK_W, 0, 32'h100, 0);
        chk("lw_c0_stall", stall, 1);
        chk("lw_c0_noreq", bus.dmem_req, 0);
        step(); idle_in();
        chk("lw_b1_stall", stall, 1);
        chk("lw_b1_req", bus.dmem_req, 1);
        chk("lw_b1_we", bus.dmem_we, 0);
        chk("lw_b1_addr", bus.dmem_addr, 32'h100);
        chk("lw_b1_be", bus.dmem_be, 4'b1111);
        step(); ack(32'hDEAD_BEEF);
        chk("lw_b2_stall", stall, 1);
        chk("lw_b2_req", bus.dmem_req, 1);
        step(); noack();
        chk("lw_done_stall", stall, 0);
        chk("lw_done_valid", ld_valid, 1);
        chk("lw_done_data", ld_data, 32'hDEAD_BEEF);
        chk("lw_done_req", bus.dmem_req, 0);
        step();
        chk("lw_idle_valid", ld_valid, 0);
        chk("lw_idle_stall", stall, 0);

        // lb / lbu 0x103
        req(1, 0, MASK_B, 0, 32'h103, 0);
        step(); idle_in(); ack(32'h80FF_FFFF);
        chk("lb_be", bus.dmem_be, 4'b1000);
        chk("lb_addr", bus.dmem_addr, 32'h100);
        step(); noack();
        chk("lb_data", ld_data, 32'hFFFF_FF80);
        chk("lb_valid", ld_valid, 1);
        step();
        req(1, 0, MASK_B, 1, 32'h103, 0);
        step(); idle_in(); ack(32'h80FF_FFFF);
        step(); noack();
        chk("lbu_data", ld_data, 32'h0000_0080);
        step();

        // lh 0x102 signed
        req(1, 0, MASK_H, 0, 32'h102, 0);
        step(); idle_in(); ack(32'h8001_1234);
        chk("lh_be", bus.dmem_be, 4'b1100);
        step(); noack();
        chk("lh_data", ld_data, 32'hFFFF_8001);
        step();

        // sh 0x202
        req(0, 1, MASK_H, 0, 32'h202, 32'h1234_ABCD);
        step(); idle_in();
        chk("sh_addr", bus.dmem_addr, 32'h200);
        chk("sh_be", bus.dmem_be, 4'b1100);
        chk("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we", bus.dmem_we, 1);
        ack(0);
        step(); noack();
        chk("sh_valid", ld_valid, 0);
        chk("sh_stall", stall, 0);
        chk("sh_ld_data_kept", ld_data, 32'hFFFF_8001);
        step();

        // both enables: store wins
        req(1, 1, MASK_B, 0, 32'h301, 32'h0000_00A5);
        step(); idle_in();
        chk("both_we", bus.dmem_we, 1);
        chk("both_be", bus.dmem_be, 4'b0010);
        chk("both_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
        chk("both_addr", bus.dmem_addr, 32'h300);
        ack(0);
        step(); noack();
        chk("both_valid", ld_valid, 0);
        step();

        // mask 00 behaves as word
        req(0, 1, 2'b00, 0, 32'h104, 32'hCAFE_BABE);
        step(); idle_in();
        chk("m0_be", bus.dmem_be, 4'b1111);
        chk("m0_wdata", bus.dmem_wdata, 32'hCAFE_BABE);
        ack(0);
        step(); noack();
        step();

        // timeout after 4 BUSY cycles
        req(1, 0, MASK_W, 0, 32'h10, 0);
        step(); idle_in();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tmo_busy%0d_req", i), bus.dmem_req, 1);
            chk($sformatf("tmo_busy%0d_err", i), bus_err, 0);
            if (i != 4) step();
        end
        step();
        chk("tmo_err", bus_err, 1);
        chk("tmo_stall", stall, 0);
        chk("tmo_valid", ld_valid, 0);
        chk("tmo_ld_data", ld_data, 0);
        chk("tmo_misalign", misalign, 0);
        step();
        chk("tmo_err_pulse", bus_err, 0);

        // ack in the 4th BUSY cycle beats the timeout
        req(1, 0, MASK_W, 0, 32'h20, 0);
        step(); idle_in();
        step(); step(); step(); ack(32'h1122_3344);
        chk("ack4_req", bus.dmem_req, 1);
        step(); noack();
        chk("ack4_err", bus_err, 0);
        chk("ack4_valid", ld_valid, 1);
        chk("ack4_data", ld_data, 32'h1122_3344);
        step();

        // reset while BUSY abandons the access
        req(1, 0, MASK_W, 0, 32'h40, 0);
        step(); idle_in();
        chk("rbusy_req", bus.dmem_req, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; ack(32'h55AA_55AA);
        chk("rbusy_req_off", bus.dmem_req, 0);
        chk("rbusy_stall", stall, 0);
        chk("rbusy_valid", ld_valid, 0);
        chk("rbusy_ld_data", ld_data, 0);
        step();
        chk("rbusy_late_valid", ld_valid, 0);
        chk("rbusy_late_err", bus_err, 0);
        chk("rbusy_late_req", bus.dmem_req, 0);
        noack();
        step();

`ifdef LSU_MISALIGN_TRAP_EN
        // misaligned word traps without a memory request
        req(1, 0, MASK_W, 0, 32'h101, 0);
        chk("mis_c0_stall", stall, 1);
        chk("mis_c0_req", bus.dmem_req, 0);
        step(); idle_in();
        chk("mis_pulse", misalign, 1);
        chk("mis_buserr", bus_err, 0);
        chk("mis_req", bus.dmem_req, 0);
        chk("mis_stall", stall, 0);
        chk("mis_valid", ld_valid, 0);
        step();
        chk("mis_clear", misalign, 0);
        chk("mis_idle_req", bus.dmem_req, 0);
`else
        // without the trap, low address bits are forced aligned
        req(1, 0, MASK_W, 0, 32'h101, 0);
        step(); idle_in();
        chk("fa_addr", bus.dmem_addr, 32'h100);
        chk("fa_be", bus.dmem_be, 4'b1111);
        chk("fa_misalign", misalign, 0);
        ack(32'hCAFE_F00D);
        step(); noack();
        chk("fa_data", ld_data, 32'hCAFE_F00D);
        step();
        req(1, 0, MASK_H, 1, 32'h103, 0);
        step(); idle_in(); ack(32'h7FFF_0000);
        chk("fa_lh_be", bus.dmem_be, 4'b1100);
        step(); noack();
        chk("fa_lh_data", ld_data, 32'h0000_7FFF);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Param TIMEOUT_CYC, default 255: max BUSY cycles awaiting dmem_ack before bus error; legal range 1..65535.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 mem_rd_en  in  1  load request from decode.
REQ-005 mem_wrt_en  in  1  store request from decode.
REQ-006 mem_mask  in  2  access size: 01 byte, 10 half, 11 word; 00 treated as word.
REQ-007 ld_unsigned  in  1  funct3[2]; zero-extend load when 1.
REQ-008 addr  in  32  byte address from ALU.
REQ-009 wdata  in  32  store data (rs2).
REQ-010 stall  out  1  core hold; high while access outstanding.
REQ-011 dmem_req / dmem_we  out  1 / 1  memory request, write strobe.
REQ-012 dmem_addr  out  32  word address, bits [1:0] = 00.
REQ-013 dmem_wdata / dmem_be  out  32 / 4  lane-steered store data, byte enables.
REQ-014 dmem_ack / dmem_rdata  in  1 / 32  access complete, read word.
REQ-015 ld_data / ld_valid  out  32 / 1  extended load result, one-cycle valid pulse.
REQ-016 bus_err / misalign  out  1 / 1  one-cycle error pulses.

Function
REQ-017 FSM states IDLE, BUSY, DONE, ERR; encoding from lsu_pkg.
REQ-018 IDLE: mem_rd_en|mem_wrt_en -> latch addr, wdata, mask, ld_unsigned, type; go BUSY; stall=1 combinationally that cycle.
REQ-019 Both enables high in IDLE: store wins, load ignored.
REQ-020 BUSY: dmem_req=1, dmem_we=store, outputs stable from latched values; stall=1; cycle counter increments.
REQ-021 BUSY and dmem_ack=1 -> DONE; load registers ld_data from dmem_rdata that edge.
REQ-022 BUSY, counter == TIMEOUT_CYC, no ack -> ERR; ack in that same cycle wins (-> DONE).
REQ-023 DONE: one cycle, stall=0, ld_valid=1 for loads only, dmem_req=0; unconditionally -> IDLE; request inputs ignored.
REQ-024 ERR: one cycle, stall=0, bus_err=1, ld_valid=0, ld_data=0; -> IDLE.
REQ-025 dmem_ack outside BUSY ignored.
REQ-026 dmem_be: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111.
REQ-027 dmem_wdata: byte replicated to four lanes, half to both halves, word unchanged.
REQ-028 Load extract: dmem_rdata >> 8*offset, low 8/16/32 bits, sign- or zero-extended per ld_unsigned.
REQ-029 Minimum store/load latency: request cycle + 1 BUSY cycle + DONE = 3 cycles, stall high first 2.

Reset
REQ-030 rst_n=0 at edge: state IDLE, counter 0, ld_data 0; all outputs 0 next cycle.
REQ-031 Reset during BUSY abandons the access; later dmem_ack ignored; no ld_valid/bus_err.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 in IDLE -> no dmem_req, go ERR-like path with misalign=1 (bus_err=0), stall=1 request cycle only.
REQ-033 Undefined: misalign tied 0; address low bits ignored per size (forced aligned).

Structure
REQ-034 Package lsu_pkg: state enum, mask encodings (MASK_B/H/W), default TIMEOUT_CYC.
REQ-035 Sub-module lsu_align: combinational byte-enable generation, store lane replication, load extraction/extension.

Verification
REQ-036 lw addr 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111, ld_data 0xDEADBEEF, ld_valid 1 cycle, stall high 3 cycles.
REQ-037 lb addr 0x103, rdata 0x80FFFFFF -> be 1000, ld_data 0xFFFFFF80; lbu -> 0x00000080.
REQ-038 sh addr 0x202, wdata 0x1234ABCD -> dmem_addr 0x200, be 1100, wdata 0xABCDABCD, we=1, no ld_valid.
REQ-039 TIMEOUT_CYC=4, no ack -> bus_err pulse after 4 BUSY cycles, ld_data 0; ack on 4th cycle -> DONE instead.
REQ-040 rst_n low in BUSY, then ack -> dmem_req 0, no ld_valid; with LSU_MISALIGN_TRAP_EN, lw addr 0x101 -> misalign pulse, no dmem_req.
